// File: rtl/pc_table.sv
// pc_table -- per-wavefront program-counter table for the fetch stage.
//
// Each of NUM_WF entries holds a PC, a fresh flag (next fetch is the first
// one after an init/recover) and an active flag. Entries are written by the
// dispatcher (init), by branch/recovery logic (recover) and by wavefront
// retire (clear). Fetch reads are registered into a one-deep output stage
// with a valid/ready handshake, and every accepted read advances the entry's
// PC by PC_INC.
//
// Optional feature macro: PC_TABLE_BYPASS_EN
//   defined   : a read that hits an entry being init/recover-written in the
//               same cycle returns the written PC (rd_first=1) and is
//               accepted even if the entry was inactive before the write.
//   undefined : such a read returns the pre-write contents, and the write
//               lands with fresh=1 (the increment is dropped).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   init_wr_en/init_wfid/init_pc    dispatcher init write
//   recover_wr_en/_wfid/_pc         branch/recovery write
//   clear_en/clear_wfid             wavefront retire
//   rd_en/rd_wfid                   fetch read request
//   rd_ack                          combinational: read accepted this cycle
//   rd_valid/rd_ready               output stage handshake
//   rd_pc/rd_first/rd_wfid_o        output stage contents
//   active_cnt                      registered count of active entries
module pc_table #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6,
   parameter int PC_W   = 32,
   parameter int PC_INC = 4,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_wr_en,
   input  logic [WFID_W-1:0] init_wfid,
   input  logic [PC_W-1:0]   init_pc,
   input  logic              recover_wr_en,
   input  logic [WFID_W-1:0] recover_wfid,
   input  logic [PC_W-1:0]   recover_pc,
   input  logic              clear_en,
   input  logic [WFID_W-1:0] clear_wfid,
   input  logic              rd_en,
   input  logic [WFID_W-1:0] rd_wfid,
   output logic              rd_ack,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [PC_W-1:0]   rd_pc,
   output logic              rd_first,
   output logic [WFID_W-1:0] rd_wfid_o,
   output logic [CNT_W-1:0]  active_cnt
);

   logic [PC_W-1:0]   pc_tbl  [NUM_WF];
   logic [PC_W-1:0]   pc_nxt  [NUM_WF];
   logic [NUM_WF-1:0] fresh, fresh_nxt;
   logic [NUM_WF-1:0] active, active_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic              rd_in_range;
   logic              rd_init_hit, rd_rec_hit, rd_wr_hit;
   logic [PC_W-1:0]   rd_wr_pc;
   logic              rd_act;
   logic [PC_W-1:0]   rd_pc_cur;
   logic              rd_fresh_cur;
   logic [PC_W-1:0]   out_pc;
   logic              out_first;

   // Read-side lookup; out-of-range ids never index the table.
   always_comb begin
      rd_in_range  = rd_wfid < WFID_W'(NUM_WF);
      rd_init_hit  = init_wr_en && (init_wfid == rd_wfid) && rd_in_range;
      rd_rec_hit   = recover_wr_en && (recover_wfid == rd_wfid) && rd_in_range;
      rd_wr_hit    = rd_init_hit || rd_rec_hit;
      // Recover outranks init, so it is also the value a bypassed read sees.
      rd_wr_pc     = rd_rec_hit ? recover_pc : init_pc;
      rd_pc_cur    = '0;
      rd_fresh_cur = 1'b0;
      rd_act       = 1'b0;
      if (rd_in_range) begin
         rd_pc_cur    = pc_tbl[rd_wfid];
         rd_fresh_cur = fresh[rd_wfid];
         rd_act       = active[rd_wfid];
      end
`ifdef PC_TABLE_BYPASS_EN
      rd_act    = rd_act || rd_wr_hit;
      out_pc    = rd_wr_hit ? rd_wr_pc : rd_pc_cur;
      out_first = rd_wr_hit ? 1'b1 : rd_fresh_cur;
`else
      out_pc    = rd_pc_cur;
      out_first = rd_fresh_cur;
`endif
      rd_ack = rd_en && rd_act && (!rd_valid || rd_ready);
   end

   // Per-entry next state: clear > recover > init > read-increment.
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         pc_nxt[i]     = pc_tbl[i];
         fresh_nxt[i]  = fresh[i];
         active_nxt[i] = active[i];
         if (clear_en && (clear_wfid == WFID_W'(i))) begin
            active_nxt[i] = 1'b0;
            fresh_nxt[i]  = 1'b0;
         end else if (recover_wr_en && (recover_wfid == WFID_W'(i))) begin
            pc_nxt[i]     = recover_pc;
            fresh_nxt[i]  = 1'b1;
            active_nxt[i] = 1'b1;
`ifdef PC_TABLE_BYPASS_EN
            if (rd_ack && (rd_wfid == WFID_W'(i))) begin
               pc_nxt[i]    = recover_pc + PC_W'(PC_INC);
               fresh_nxt[i] = 1'b0;
            end
`endif
         end else if (init_wr_en && (init_wfid == WFID_W'(i))) begin
            pc_nxt[i]     = init_pc;
            fresh_nxt[i]  = 1'b1;
            active_nxt[i] = 1'b1;
`ifdef PC_TABLE_BYPASS_EN
            if (rd_ack && (rd_wfid == WFID_W'(i))) begin
               pc_nxt[i]    = init_pc + PC_W'(PC_INC);
               fresh_nxt[i] = 1'b0;
            end
`endif
         end else if (rd_ack && (rd_wfid == WFID_W'(i))) begin
            pc_nxt[i]    = pc_tbl[i] + PC_W'(PC_INC);
            fresh_nxt[i] = 1'b0;
         end
         cnt_nxt = cnt_nxt + CNT_W'(active_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WF; i++) pc_tbl[i] <= '0;
         fresh      <= '0;
         active     <= '0;
         active_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_WF; i++) pc_tbl[i] <= pc_nxt[i];
         fresh      <= fresh_nxt;
         active     <= active_nxt;
         active_cnt <= cnt_nxt;
      end
   end

   // Output stage: load on accept, drop valid when consumed, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid  <= 1'b0;
         rd_pc     <= '0;
         rd_first  <= 1'b0;
         rd_wfid_o <= '0;
      end else if (rd_ack) begin
         rd_valid  <= 1'b1;
         rd_pc     <= out_pc;
         rd_first  <= out_first;
         rd_wfid_o <= rd_wfid;
      end else if (rd_ready) begin
         rd_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_table.sv
module tb_pc_table;

   localparam bit BYP =
`ifdef PC_TABLE_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_wr_en, recover_wr_en, clear_en, rd_en, rd_ready;
   logic [5:0]  init_wfid, recover_wfid, clear_wfid, rd_wfid;
   logic [31:0] init_pc, recover_pc;
   logic        rd_ack, rd_valid, rd_first;
   logic [31:0] rd_pc;
   logic [5:0]  rd_wfid_o, active_cnt;

   int checks = 0;
   int errors = 0;

   pc_table dut (
      .clk(clk), .rst_n(rst_n),
      .init_wr_en(init_wr_en), .init_wfid(init_wfid), .init_pc(init_pc),
      .recover_wr_en(recover_wr_en), .recover_wfid(recover_wfid), .recover_pc(recover_pc),
      .clear_en(clear_en), .clear_wfid(clear_wfid),
      .rd_en(rd_en), .rd_wfid(rd_wfid), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
      .rd_first(rd_first), .rd_wfid_o(rd_wfid_o), .active_cnt(active_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ie; logic [5:0] iw; logic [31:0] ip;
      logic        re; logic [5:0] rw; logic [31:0] rp;
      logic        ce; logic [5:0] cw;
      logic        rd; logic [5:0] rdw; logic rr;
      logic        ack; logic v; logic [31:0] pc; logic f; logic [5:0] w; logic [5:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int ie, int iw, longint ip, int re, int rw, longint rp,
                               int ce, int cw, int rd, int rdw, int rr,
                               int ack, int v, longint pc, int f, int w, int cnt);
      vec_t t;
      t.ie = 1'(ie); t.iw = 6'(iw); t.ip = 32'(ip);
      t.re = 1'(re); t.rw = 6'(rw); t.rp = 32'(rp);
      t.ce = 1'(ce); t.cw = 6'(cw);
      t.rd = 1'(rd); t.rdw = 6'(rdw); t.rr = 1'(rr);
      t.ack = 1'(ack); t.v = 1'(v); t.pc = 32'(pc); t.f = 1'(f); t.w = 6'(w); t.cnt = 6'(cnt);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      init_wr_en = 0; init_wfid = 0; init_pc = 0;
      recover_wr_en = 0; recover_wfid = 0; recover_pc = 0;
      clear_en = 0; clear_wfid = 0; rd_en = 0; rd_wfid = 0; rd_ready = 1;
   endtask

   task automatic apply(input vec_t t, input int k);
      @(negedge clk);
      init_wr_en = t.ie; init_wfid = t.iw; init_pc = t.ip;
      recover_wr_en = t.re; recover_wfid = t.rw; recover_pc = t.rp;
      clear_en = t.ce; clear_wfid = t.cw;
      rd_en = t.rd; rd_wfid = t.rdw; rd_ready = t.rr;
      #1 chk($sformatf("v%0d_ack", k), 32'(rd_ack), 32'(t.ack));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", k), 32'(rd_valid), 32'(t.v));
      if (t.v) begin
         chk($sformatf("v%0d_pc", k), rd_pc, t.pc);
         chk($sformatf("v%0d_first", k), 32'(rd_first), 32'(t.f));
         chk($sformatf("v%0d_wfid", k), 32'(rd_wfid_o), 32'(t.w));
      end
      chk($sformatf("v%0d_cnt", k), 32'(active_cnt), 32'(t.cnt));
   endtask

   initial begin
      //          ie iw ip          re rw rp    ce cw rd rdw rr  ack v  pc           f  w  cnt
      vecs.push_back(mk(1, 3, 'h100,      0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0,          0, 0, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, 'h100,      1, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, 'h104,      0, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, 'h108,      0, 3, 1));
      // stalled output: reads rejected, output held
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 0,  0, 1, 'h108,      0, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 0,  0, 1, 'h108,      0, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, 'h10C,      0, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0,          0, 0, 1));
      // recover and init to the same entry: recover wins
      vecs.push_back(mk(1, 3, 'h300,      1, 3, 'h200, 0, 0, 0, 0, 1,  0, 0, 0,          0, 0, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, 'h200,      1, 3, 1));
      // read and recover to the same entry
      vecs.push_back(mk(0, 0, 0,          1, 3, 'h400, 0, 0, 1, 3, 1,  1, 1, BYP ? 'h400 : 'h204, BYP ? 1 : 0, 3, 1));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 3, 1,  1, 1, BYP ? 'h404 : 'h400, BYP ? 0 : 1, 3, 1));
      // PC wrap on the last entry, out-of-range id, inactive entry
      vecs.push_back(mk(1, 39, 'hFFFFFFFC, 0, 0, 0,    0, 0, 0, 0, 1,  0, 0, 0,          0, 0, 2));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 39, 1, 1, 1, 'hFFFFFFFC, 1, 39, 2));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 39, 1, 1, 1, 'h0,        0, 39, 2));
      vecs.push_back(mk(1, 40, 'h50,      0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0,          0, 0, 2));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 40, 1, 0, 0, 0,          0, 0, 2));
      vecs.push_back(mk(0, 0, 0,          0, 0, 0,     0, 0, 1, 7, 1,  0, 0, 0,          0, 0, 2));
      // distinct entries written while another is read
      vecs.push_back(mk(1, 10, 'h1000,    1, 11, 'h1100, 0, 0, 1, 3, 1, 1, 1, BYP ? 'h408 : 'h404, 0, 3, 4));
      // read of an inactive entry that is being initialised
      vecs.push_back(mk(1, 20, 'h2000,    0, 0, 0,     0, 0, 1, 20, 1, BYP ? 1 : 0, BYP ? 1 : 0, 'h2000, 1, 20, 5));

      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_pc", rd_pc, 32'd0);
      chk("rst_first", 32'(rd_first), 32'd0);
      chk("rst_wfid", 32'(rd_wfid_o), 32'd0);
      chk("rst_cnt", 32'(active_cnt), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

      // Fill every entry, then retire wf5 while reading it.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         idle_inputs();
         init_wr_en = 1; init_wfid = 6'(i); init_pc = 32'(i * 16);
      end
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 40), 100);
      apply(mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 5, 1, 1, 1, 'h50, 1, 5, 39), 101);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 'h50, 1, 5, 39), 102);

      // Asynchronous reset while the output stage holds a PC.
      @(negedge clk);
      idle_inputs();
      rd_ready = 0;
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(rd_valid), 32'd0);
      chk("async_rst_cnt", 32'(active_cnt), 32'd0);
      chk("async_rst_pc", rd_pc, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
